mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle CPU between two requesters:
  - the CPU, whose accesses are driven by the multicycle controller's fetch, load and store states;
  - a debug/loader port used for program load and memory inspection.
- Sequences each access through issue, fixed-latency wait and response.
- Returns a one-cycle acknowledge to the winner. The CPU controller holds its current state while cpu_stall is high.
- The CPU has priority; a starvation guard guarantees debug forward progress.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LAT, 1, memory read latency in cycles (legal 1..7); mem_rdata is valid LAT cycles after the mem_en cycle.
- STARVE, 4, consecutive CPU grants allowed while dbg_req is pending before debug is forced (legal 1..15).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_req  input  1  CPU access request; held until cpu_ack.
- cpu_we  input  1  CPU write when 1, read when 0.
- cpu_addr  input  AW  CPU address.
- cpu_wdata  input  DW  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse to the CPU.
- cpu_stall  output  1  combinational: cpu_req & ~cpu_ack.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack: same as the cpu_* ports, for the debug requester.
- rdata  output  DW  read data; valid in the ack cycle and held until the next read response.
- mem_en  output  1  memory access strobe (one cycle per access).
- mem_we  output  1  memory write enable, qualified by mem_en.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data.
- busy  output  1  high in every state except IDLE.
- grant_dbg  output  1  current or last grant owner (1 = debug).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE; all outputs 0, including rdata, mem_* and grant_dbg; starvation counter 0.
- Reset mid-operation: the in-flight access is abandoned and no ack is issued. A write already strobed by mem_en is not undone.
- Requester rule: req, we, addr and wdata stay stable from assertion until the ack cycle. The requester drops req, or presents a new request, on the edge after ack.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay.
  - Only cpu_req: grant the CPU.
  - Only dbg_req: grant debug.
  - Both pending: grant debug if the starvation count equals STARVE, else grant the CPU.
  - On a grant: register the winner's we/addr/wdata into mem_*, set grant_dbg, go to ISSUE.
- ISSUE:
  - mem_en=1 for exactly this cycle.
  - Write: next state RESP.
  - Read: load the wait counter with LAT-1. If LAT=1 go to RESP, else go to WAIT.
- WAIT: decrement the counter; go to RESP when it reaches 0.
- RESP:
  - Read: capture mem_rdata into rdata.
  - Pulse the winner's ack.
  - Next state IDLE.
- Latency, request seen in IDLE at cycle 0:
  - mem_en in cycle 1.
  - Read ack in cycle 1+LAT.
  - Write ack in cycle 2.
  - Back-to-back accesses have one IDLE bubble.
- Starvation counter (4 bits, saturating at STARVE):
  - Increments on a CPU grant while dbg_req=1.
  - Clears on a debug grant.
  - Clears on a CPU grant while dbg_req=0.
- Simultaneous events: a request arriving in any state other than IDLE waits. No preemption of an in-flight access.
- mem_addr, mem_we and mem_wdata hold their values after an access ends; only mem_en qualifies them.
- A request whose ack is pulsing is ignored in that cycle.

Decomposition:
- Shared package (mem_arb_pkg): FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3), owner constants (OWN_CPU=0, OWN_DBG=1), legal LAT/STARVE bounds.
- One natural sub-module: mem_lat_timer, a loadable down-counter with a zero flag for the WAIT state.
- Arbitration and the starvation counter stay in the top module.

Test Plan:
- Single CPU read, LAT=1, cpu_addr=0x10, mem_rdata=0xDEADBEEF -> mem_en in cycle 1, cpu_ack and rdata=0xDEADBEEF in cycle 2, cpu_stall high in cycles 0-1.
- Single debug write, LAT=3, dbg_addr=0x20, dbg_wdata=0x55 -> mem_en=mem_we=1 with addr 0x20 and data 0x55 in cycle 1, dbg_ack in cycle 2, grant_dbg=1.
- CPU read with LAT=3 -> WAIT occupies cycles 2-3, cpu_ack in cycle 4, rdata equals the mem_rdata sampled in cycle 4.
- CPU and debug both requesting continuously, STARVE=4 -> grant sequence CPU, CPU, CPU, CPU, DBG, then repeating; never 5 consecutive CPU grants.
- Reset asserted in WAIT of a CPU read -> next cycle state IDLE, no cpu_ack, all outputs 0; re-asserted cpu_req then completes normally.
- dbg_req alone, then cpu_req raised during debug ISSUE -> the debug access completes first; the CPU is granted in the IDLE cycle after dbg_ack.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, owner codes, parameter bounds.
// Pure definitions; no latency or flow control of its own.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   localparam int LAT_MIN    = 1;
   localparam int LAT_MAX    = 7;
   localparam int STARVE_MIN = 1;
   localparam int STARVE_MAX = 15;

   // Timer must hold LAT_MAX-1; starvation counter must hold STARVE_MAX.
   localparam int TMR_W = 3;
   localparam int STV_W = 4;

   function automatic logic [TMR_W-1:0] lat_load(input int lat);
      return TMR_W'(lat - 1);
   endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter timing the memory read latency in the WAIT state.
// Load/decrement take effect on the next edge; zero flags the cycle whose decrement lands on zero.
module mem_lat_timer
   import mem_arb_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   // An already-empty counter also reports zero so WAIT can never lock up.
   assign zero = (count == W'(1)) || (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory between the CPU and a debug/loader port; CPU first, starvation-guarded.
// Read ack 1+LAT cycles after the grant cycle, write ack 2 cycles after; losers and late arrivals are held off via req/ack.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int LAT    = 1,
   parameter int STARVE = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_ack,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          grant_dbg
);

   if ((LAT < LAT_MIN) || (LAT > LAT_MAX)) begin : g_lat_range
      $error("mem_port_arbiter: LAT out of range");
   end
   if ((STARVE < STARVE_MIN) || (STARVE > STARVE_MAX)) begin : g_starve_range
      $error("mem_port_arbiter: STARVE out of range");
   end

   localparam logic [TMR_W-1:0] LAT_LOAD  = lat_load(LAT);
   localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE);

   state_t           state;
   state_t           state_nxt;
   logic             grant;
   logic             pick_dbg;
   logic             tmr_load;
   logic             tmr_dec;
   logic             tmr_zero;
   logic             starve_hit;
   logic [STV_W-1:0] starve_cnt;
   logic [DW-1:0]    rdata_q;
   logic             resp_rd;

   assign starve_hit = (starve_cnt == STARVE_LIM);

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      pick_dbg  = 1'b0;
      tmr_load  = 1'b0;
      tmr_dec   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cpu_req || dbg_req) begin
               grant     = 1'b1;
               pick_dbg  = dbg_req && (!cpu_req || starve_hit);
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (mem_we) begin
               state_nxt = ST_RESP;
            end else begin
               tmr_load  = 1'b1;
               state_nxt = (LAT == 1) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            tmr_dec = 1'b1;
            if (tmr_zero) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Winner's request is frozen into mem_* at grant and held after the access ends.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         grant_dbg  <= OWN_CPU;
         starve_cnt <= '0;
         rdata_q    <= '0;
      end else begin
         if (grant) begin
            mem_we    <= pick_dbg ? dbg_we    : cpu_we;
            mem_addr  <= pick_dbg ? dbg_addr  : cpu_addr;
            mem_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
            grant_dbg <= pick_dbg ? OWN_DBG   : OWN_CPU;
            if (pick_dbg || !dbg_req) begin
               starve_cnt <= '0;
            end else if (!starve_hit) begin
               starve_cnt <= starve_cnt + STV_W'(1);
            end
         end
         if (resp_rd) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   mem_lat_timer #(
      .W (TMR_W)
   ) u_lat_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (LAT_LOAD),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // Read data bypasses the capture register so it is already valid in the ack cycle.
   assign resp_rd   = (state == ST_RESP) && !mem_we;
   assign rdata     = resp_rd ? mem_rdata : rdata_q;
   assign mem_en    = (state == ST_ISSUE);
   assign busy      = (state != ST_IDLE);
   assign cpu_ack   = (state == ST_RESP) && (grant_dbg == OWN_CPU);
   assign dbg_ack   = (state == ST_RESP) && (grant_dbg == OWN_DBG);
   assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: LAT=1 and LAT=3 instances share stimulus, one is monitored at a time.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic [31:0] rd_base;
   logic        rd_track;
   logic [31:0] mem_rdata;
   int          cyc = 0;
   logic        sel3;

   logic        cpu_ack_1, cpu_stall_1, dbg_ack_1, mem_en_1, mem_we_1, busy_1, grant_dbg_1;
   logic [31:0] rdata_1, mem_addr_1, mem_wdata_1;
   logic        cpu_ack_3, cpu_stall_3, dbg_ack_3, mem_en_3, mem_we_3, busy_3, grant_dbg_3;
   logic [31:0] rdata_3, mem_addr_3, mem_wdata_3;

   logic        v_cpu_ack, v_cpu_stall, v_dbg_ack, v_mem_en, v_mem_we, v_busy, v_grant_dbg;
   logic [31:0] v_rdata, v_mem_addr, v_mem_wdata;

   typedef struct {
      logic        dbg;
      logic        rd;
      logic [31:0] data;
      int          cyc;
   } ack_exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          cyc;
   } mem_exp_t;

   ack_exp_t ack_q[$];
   mem_exp_t mem_q[$];
   int       checks = 0;
   int       errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: fixed word, or a word that changes every cycle to expose the capture cycle.
   assign mem_rdata = rd_track ? (rd_base + cyc) : rd_base;

   mem_port_arbiter #(.AW(32), .DW(32), .LAT(1), .STARVE(4)) u_dut1 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack_1), .cpu_stall(cpu_stall_1),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack_1), .rdata(rdata_1),
      .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
      .mem_rdata(mem_rdata), .busy(busy_1), .grant_dbg(grant_dbg_1)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .LAT(3), .STARVE(4)) u_dut3 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack_3), .cpu_stall(cpu_stall_3),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack_3), .rdata(rdata_3),
      .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
      .mem_rdata(mem_rdata), .busy(busy_3), .grant_dbg(grant_dbg_3)
   );

   always_comb begin
      v_cpu_ack   = sel3 ? cpu_ack_3   : cpu_ack_1;
      v_cpu_stall = sel3 ? cpu_stall_3 : cpu_stall_1;
      v_dbg_ack   = sel3 ? dbg_ack_3   : dbg_ack_1;
      v_mem_en    = sel3 ? mem_en_3    : mem_en_1;
      v_mem_we    = sel3 ? mem_we_3    : mem_we_1;
      v_busy      = sel3 ? busy_3      : busy_1;
      v_grant_dbg = sel3 ? grant_dbg_3 : grant_dbg_1;
      v_rdata     = sel3 ? rdata_3     : rdata_1;
      v_mem_addr  = sel3 ? mem_addr_3  : mem_addr_1;
      v_mem_wdata = sel3 ? mem_wdata_3 : mem_wdata_1;
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void push_ack(input logic dbg, input logic rd, input logic [31:0] data, input int c);
      ack_exp_t e;
      e.dbg = dbg; e.rd = rd; e.data = data; e.cyc = c;
      ack_q.push_back(e);
   endfunction

   function automatic void push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int c);
      mem_exp_t e;
      e.we = we; e.addr = addr; e.wdata = wdata; e.cyc = c;
      mem_q.push_back(e);
   endfunction

   // Monitor: pops an expectation whenever the monitored DUT strobes memory or acknowledges.
   always @(negedge clk) begin
      ack_exp_t ae;
      mem_exp_t me;
      if (v_cpu_ack || v_dbg_ack) begin
         if (ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: cpu_ack=%b dbg_ack=%b at cycle %0d, expected none", v_cpu_ack, v_dbg_ack, cyc);
         end else begin
            ae = ack_q.pop_front();
            chk("ack_owner", 32'({v_cpu_ack, v_dbg_ack}), 32'({~ae.dbg, ae.dbg}));
            chk("ack_cycle", cyc, ae.cyc);
            if (ae.rd) chk("ack_rdata", v_rdata, ae.data);
         end
      end
      if (v_mem_en) begin
         if (mem_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem_en: addr %h at cycle %0d, expected none", v_mem_addr, cyc);
         end else begin
            me = mem_q.pop_front();
            chk("mem_cycle", cyc, me.cyc);
            chk("mem_we", 32'(v_mem_we), 32'(me.we));
            chk("mem_addr", v_mem_addr, me.addr);
            if (me.we) chk("mem_wdata", v_mem_wdata, me.wdata);
         end
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      repeat (2) next_cyc();
      reset = 1'b0;
   endtask

   task automatic cpu_run(input int n, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      int got = 0;
      int t   = 0;
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
      while (got < n && t < 100) begin
         @(negedge clk);
         t++;
         if (v_cpu_ack) got++;
      end
      if (got < n) begin
         checks++;
         errors++;
         $display("FAIL cpu_timeout: acks %0d expected %0d", got, n);
      end
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
   endtask

   task automatic dbg_run(input int n, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      int got = 0;
      int t   = 0;
      dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
      while (got < n && t < 100) begin
         @(negedge clk);
         t++;
         if (v_dbg_ack) got++;
      end
      if (got < n) begin
         checks++;
         errors++;
         $display("FAIL dbg_timeout: acks %0d expected %0d", got, n);
      end
      @(posedge clk);
      #1;
      dbg_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int          c;
      logic [31:0] exp_rd;
      reset = 1'b1; sel3 = 1'b0; rd_base = '0; rd_track = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

      // Reset state of both instances.
      do_reset();
      chk("rst1_ctrl", 32'({busy_1, mem_en_1, mem_we_1, cpu_ack_1, dbg_ack_1, grant_dbg_1, cpu_stall_1}), 32'd0);
      chk("rst1_data", mem_addr_1 | mem_wdata_1 | rdata_1, 32'd0);
      chk("rst3_ctrl", 32'({busy_3, mem_en_3, mem_we_3, cpu_ack_3, dbg_ack_3, grant_dbg_3, cpu_stall_3}), 32'd0);

      // CPU read, LAT=1.
      sel3 = 1'b0; rd_base = 32'hDEADBEEF; rd_track = 1'b0;
      c = cyc;
      push_mem(1'b0, 32'h10, 32'h0, c + 1);
      push_ack(1'b0, 1'b1, 32'hDEADBEEF, c + 2);
      fork
         cpu_run(1, 1'b0, 32'h10, 32'h0);
         begin
            @(negedge clk); chk("t1_stall_c0", 32'(v_cpu_stall), 32'd1);
            @(negedge clk); chk("t1_stall_c1", 32'(v_cpu_stall), 32'd1);
            @(negedge clk); chk("t1_stall_c2", 32'(v_cpu_stall), 32'd0);
         end
      join
      rd_base = 32'h0;
      next_cyc();
      next_cyc();
      chk("t1_rdata_hold", v_rdata, 32'hDEADBEEF);

      // Debug write, LAT=3 instance.
      sel3 = 1'b1;
      do_reset();
      c = cyc;
      push_mem(1'b1, 32'h20, 32'h55, c + 1);
      push_ack(1'b1, 1'b0, 32'h0, c + 2);
      dbg_run(1, 1'b1, 32'h20, 32'h55);
      chk("t2_grant_dbg", 32'(v_grant_dbg), 32'd1);

      // Both requesting continuously: C C C C D C C C C D.
      sel3 = 1'b0;
      do_reset();
      c = cyc;
      for (int k = 0; k < 10; k++) begin
         if (k == 4 || k == 9) begin
            push_mem(1'b1, 32'h200, 32'hD0, c + 3 * k + 1);
            push_ack(1'b1, 1'b0, 32'h0, c + 3 * k + 2);
         end else begin
            push_mem(1'b1, 32'h100, 32'hC0, c + 3 * k + 1);
            push_ack(1'b0, 1'b0, 32'h0, c + 3 * k + 2);
         end
      end
      fork
         cpu_run(8, 1'b1, 32'h100, 32'hC0);
         dbg_run(2, 1'b1, 32'h200, 32'hD0);
      join

      // CPU read, LAT=3: data sampled in the ack cycle.
      sel3 = 1'b1; rd_base = 32'h1000_0000; rd_track = 1'b1;
      c = cyc;
      exp_rd = 32'h1000_0000 + 32'(c + 4);
      push_mem(1'b0, 32'h30, 32'h0, c + 1);
      push_ack(1'b0, 1'b1, exp_rd, c + 4);
      cpu_run(1, 1'b0, 32'h30, 32'h0);
      rd_track = 1'b0; rd_base = 32'h0;
      next_cyc();
      chk("t3_rdata_hold", v_rdata, exp_rd);

      // Reset during WAIT abandons the read; a fresh read then completes.
      rd_base = 32'h77;
      c = cyc;
      push_mem(1'b0, 32'h40, 32'h0, c + 1);
      cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'h99; cpu_req = 1'b1;
      next_cyc();
      next_cyc();
      chk("t5_busy_in_wait", 32'(busy_3), 32'd1);
      reset = 1'b1; cpu_req = 1'b0;
      next_cyc();
      chk("t5_rst_ctrl", 32'({busy_3, mem_en_3, mem_we_3, cpu_ack_3, dbg_ack_3, grant_dbg_3}), 32'd0);
      chk("t5_rst_addr", mem_addr_3, 32'd0);
      chk("t5_rst_wdata", mem_wdata_3, 32'd0);
      chk("t5_rst_rdata", rdata_3, 32'd0);
      reset = 1'b0;
      repeat (3) next_cyc();
      rd_base = 32'h2000_0000; rd_track = 1'b1;
      c = cyc;
      push_mem(1'b0, 32'h44, 32'h0, c + 1);
      push_ack(1'b0, 1'b1, 32'h2000_0000 + 32'(c + 4), c + 4);
      cpu_run(1, 1'b0, 32'h44, 32'h99);

      // CPU arrives during debug ISSUE: waits, then wins the next IDLE.
      rd_base = 32'h3000_0000;
      c = cyc;
      push_mem(1'b1, 32'h60, 32'h66, c + 1);
      push_ack(1'b1, 1'b0, 32'h0, c + 2);
      push_mem(1'b0, 32'h70, 32'h0, c + 4);
      push_ack(1'b0, 1'b1, 32'h3000_0000 + 32'(c + 7), c + 7);
      fork
         dbg_run(1, 1'b1, 32'h60, 32'h66);
         begin
            next_cyc();
            cpu_run(1, 1'b0, 32'h70, 32'h0);
         end
      join

      repeat (4) next_cyc();
      chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
      chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
